// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 16:1 bit-select mux among 16 requesters.
// Drives the mux select and a one-hot grant, and registers the selected bit.
module mux_rr_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] req,
   input  logic [15:0] w,
   output logic [15:0] gnt,
   output logic [3:0]  s,
   output logic        f,
   output logic        valid,
   output logic        busy
);

   localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t             state_q, state_d;
   logic [3:0]         ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [15:0]        gnt_q, gnt_d;
   logic [3:0]         s_q, s_d;
   logic               f_q, f_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic [3:0]         pick_idx;

   // Scan from the highest offset down so the lowest offset above ptr wins.
   always_comb begin
      pick_idx = ptr_q;
      for (int k = 15; k >= 0; k--) begin
         if (req[ptr_q + 4'(k)]) pick_idx = ptr_q + 4'(k);
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      s_d     = s_q;
      f_d     = f_q;
      valid_d = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            gnt_d = 16'h0000;
            if (req != 16'h0000) begin
               gnt_d   = 16'h0001 << pick_idx;
               s_d     = pick_idx;
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            f_d     = w[s_q];
            valid_d = 1'b1;
            // s is left alone on release so the mux keeps its last route.
            if (!req[s_q] || cnt_q == CNT_W'(MAX_HOLD - 1)) begin
               gnt_d   = 16'h0000;
               busy_d  = 1'b0;
               ptr_d   = s_q + 4'd1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= 4'd0;
         cnt_q   <= '0;
         gnt_q   <= 16'h0000;
         s_q     <= 4'd0;
         f_q     <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         s_q     <= s_d;
         f_q     <= f_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt   = gnt_q;
   assign s     = s_q;
   assign f     = f_q;
   assign valid = valid_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: per-cycle comparison against an
// owner/hold-count model plus directed literal checks of each scenario.
module tb_mux_rr_arbiter;

   localparam int MAX_HOLD = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] req;
   logic [15:0] w;
   logic [15:0] gnt;
   logic [3:0]  s;
   logic        f;
   logic        valid;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .w     (w),
      .gnt   (gnt),
      .s     (s),
      .f     (f),
      .valid (valid),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
      chk(name, act, exp);
      $display("check %-16s got %h expected %h", name, act, exp);
   endtask

   // Model: who owns the mux, how many cycles it has held it, and where the
   // next search starts. Outputs follow from those quantities directly.
   int         owner = -1;
   int         held  = 0;
   int         mptr  = 0;
   logic [3:0] m_s   = 4'd0;
   logic       m_f   = 1'b0;
   logic       m_valid = 1'b0;
   bit         m_started = 1'b0;

   always @(posedge clk) begin
      m_started = 1'b1;
      if (reset) begin
         owner = -1; held = 0; mptr = 0; m_s = 4'd0; m_f = 1'b0; m_valid = 1'b0;
      end else if (owner < 0) begin
         m_valid = 1'b0;
         for (int k = 0; k < 16; k++) begin
            if (owner < 0 && req[(mptr + k) % 16]) begin
               owner = (mptr + k) % 16;
               held  = 1;
               m_s   = 4'((mptr + k) % 16);
            end
         end
      end else begin
         m_f     = w[owner];
         m_valid = 1'b1;
         if (!req[owner] || held == MAX_HOLD) begin
            mptr  = (owner + 1) % 16;
            owner = -1;
         end else begin
            held++;
         end
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         chk("gnt",   gnt, (owner < 0) ? 16'h0000 : (16'h0001 << owner));
         chk("s",     {12'h000, s}, {12'h000, m_s});
         chk("f",     {15'h0000, f}, {15'h0000, m_f});
         chk("valid", {15'h0000, valid}, {15'h0000, m_valid});
         chk("busy",  {15'h0000, busy}, {15'h0000, owner >= 0});
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int got[$];
      logic prev_busy;

      // Reset with all requests asserted
      reset = 1'b1; req = 16'hFFFF; w = 16'h0000;
      tick(); tick();
      lit("rst_gnt",   gnt, 16'h0000);
      lit("rst_s",     {12'h000, s}, 16'h0000);
      lit("rst_f",     {15'h0000, f}, 16'h0000);
      lit("rst_valid", {15'h0000, valid}, 16'h0000);
      lit("rst_busy",  {15'h0000, busy}, 16'h0000);
      reset = 1'b0;
      tick();
      lit("first_gnt", gnt, 16'h0001);

      // Lone requester: 4 on, 1 off, repeating
      do_reset();
      req = 16'h0020;
      tick();
      lit("lone_s", {12'h000, s}, 16'h0005);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) tick();
         lit($sformatf("lone_cyc%0d", i), gnt, ((i % 5) != 4) ? 16'h0020 : 16'h0000);
      end

      // Two requesters alternate 3,10,3,10
      do_reset();
      req = 16'h0408;
      prev_busy = 1'b0;
      for (int i = 0; i < 25 && got.size() < 4; i++) begin
         tick();
         if (busy && !prev_busy) got.push_back(int'(s));
         prev_busy = busy;
      end
      lit("two_count", 16'(got.size()), 16'd4);
      if (got.size() == 4) begin
         lit("two_g0", 16'(got[0]), 16'd3);
         lit("two_g1", 16'(got[1]), 16'd10);
         lit("two_g2", 16'(got[2]), 16'd3);
         lit("two_g3", 16'(got[3]), 16'd10);
      end

      // Wrap-around 14 -> 15 -> 0 with early release of 15
      do_reset();
      req = 16'h4000;
      tick();
      lit("wrap_g14", gnt, 16'h4000);
      req = 16'h8001;
      tick();
      lit("wrap_rel14", gnt, 16'h0000);
      tick();
      lit("wrap_g15", gnt, 16'h8000);
      tick();
      lit("wrap_g15_c2", gnt, 16'h8000);
      req = 16'h0001;
      tick();
      lit("early_rel", gnt, 16'h0000);
      tick();
      lit("wrap_g0", gnt, 16'h0001);

      // Data path through index 7: 1,0,1,1
      do_reset();
      req = 16'h0080; w = 16'h0000;
      tick();
      lit("data_s", {12'h000, s}, 16'h0007);
      w = 16'h0080; tick();
      lit("data_f0", {14'h0000, valid, f}, 16'h0003);
      w = 16'h0000; tick();
      lit("data_f1", {14'h0000, valid, f}, 16'h0002);
      w = 16'h0080; tick();
      lit("data_f2", {14'h0000, valid, f}, 16'h0003);
      w = 16'h0080; tick();
      lit("data_f3", {14'h0000, valid, f}, 16'h0003);
      tick();
      lit("data_bubble_v", {15'h0000, valid}, 16'h0000);

      // Reset on the 2nd grant cycle of index 9
      do_reset();
      req = 16'h0200; w = 16'h0000;
      tick();
      lit("mid_g9", gnt, 16'h0200);
      tick();
      reset = 1'b1; req = 16'h0201;
      tick();
      lit("mid_rst_gnt",  gnt, 16'h0000);
      lit("mid_rst_busy", {15'h0000, busy}, 16'h0000);
      lit("mid_rst_s",    {12'h000, s}, 16'h0000);
      reset = 1'b0;
      tick();
      lit("mid_g0", gnt, 16'h0001);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
